// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types and helpers for the gshare predictor: FSM encoding, counter init,
// saturating counter arithmetic and the index hash.
package bp_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Helpers work on 32-bit values; callers slice down to their own widths.
    function automatic logic [31:0] ctr_max(input int ctr_bits);
        return (ctr_bits >= 32) ? 32'hffff_ffff : ((32'd1 << ctr_bits) - 32'd1);
    endfunction

    // Weakly not-taken: one below the taken threshold.
    function automatic logic [31:0] ctr_init(input int ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int ctr_bits);
        return (v == ctr_max(ctr_bits)) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

    // Both operands arrive zero-extended, so the history lands on the low index bits.
    function automatic logic [31:0] gshare_hash(input logic [31:0] pc_bits, input logic [31:0] ghr_bits);
        return pc_bits ^ ghr_bits;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_pht.sv
// Pattern history table: saturating counters, one registered read port plus a
// combinational peek for same-cycle history speculation, and one RMW update port.
module bp_pht
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sweep_en,
    input  logic [INDEX_BITS-1:0] sweep_idx,
    input  logic                  rd_en,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_taken_now,
    output logic [CTR_BITS-1:0]   rd_ctr,
    input  logic                  upd_en,
    input  logic [INDEX_BITS-1:0] upd_idx,
    input  logic                  upd_taken
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [CTR_BITS-1:0] mem [ENTRIES];
    logic [31:0]         init32;
    logic [31:0]         upd_cur32;
    logic [31:0]         upd_next32;
    logic                unused_bits;

    assign init32 = ctr_init(CTR_BITS);

    always_comb begin
        upd_cur32  = 32'(mem[upd_idx]);
        upd_next32 = upd_taken ? sat_inc(upd_cur32, CTR_BITS) : sat_dec(upd_cur32);
    end

    // Sweep owns the write port while it runs.
    always_ff @(posedge clk) begin
        if (sweep_en)
            mem[sweep_idx] <= init32[CTR_BITS-1:0];
        else if (upd_en)
            mem[upd_idx] <= upd_next32[CTR_BITS-1:0];
    end

    // Reads see the array before this edge's write: read-before-write.
    assign rd_taken_now = mem[rd_idx][CTR_BITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_ctr <= '0;
        else if (rd_en)
            rd_ctr <= mem[rd_idx];
    end

    assign unused_bits = ^{init32, upd_next32};

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: PC xor speculative global history into a PHT,
// history repair on mispredict, clear sweep after reset/flush, saturating stats.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 8,
    parameter int GHR_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    output logic                  ready,
    input  logic                  predict_req,
    input  logic [PC_WIDTH-1:0]   predict_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [GHR_BITS-1:0]   pred_ghr,
    input  logic                  update_valid,
    input  logic [PC_WIDTH-1:0]   update_pc,
    input  logic [GHR_BITS-1:0]   update_ghr,
    input  logic                  update_taken,
    input  logic                  update_mispredict,
    output logic [STAT_WIDTH-1:0] stat_predictions,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    state_t                state, state_n;
    logic [INDEX_BITS-1:0] ptr;
    logic [GHR_BITS-1:0]   ghr, ghr_n;
    logic [31:0]           pidx32, uidx32;
    logic [INDEX_BITS-1:0] pidx, uidx;
    logic                  in_run, upd_go, repair, pred_go, pred_dir;
    logic [GHR_BITS:0]     pred_shift, rep_shift;
    logic [CTR_BITS-1:0]   rd_ctr;
    logic                  unused_bits;

    assign pidx32 = gshare_hash(32'(predict_pc[INDEX_BITS+1:2]), 32'(ghr));
    assign uidx32 = gshare_hash(32'(update_pc[INDEX_BITS+1:2]), 32'(update_ghr));
    assign pidx   = pidx32[INDEX_BITS-1:0];
    assign uidx   = uidx32[INDEX_BITS-1:0];

    // A mispredict repair in the same cycle drops the request; the core re-requests.
    assign in_run  = (state == ST_RUN) && !flush;
    assign upd_go  = in_run && update_valid;
    assign repair  = upd_go && update_mispredict;
    assign pred_go = in_run && predict_req && !repair;
    assign ready   = (state == ST_RUN);

    bp_pht #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_BITS   (CTR_BITS)
    ) u_pht (
        .clk          (clk),
        .rst          (rst),
        .sweep_en     (state == ST_INIT),
        .sweep_idx    (ptr),
        .rd_en        (pred_go),
        .rd_idx       (pidx),
        .rd_taken_now (pred_dir),
        .rd_ctr       (rd_ctr),
        .upd_en       (upd_go),
        .upd_idx      (uidx),
        .upd_taken    (update_taken)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_INIT: if (ptr == LAST_IDX) state_n = ST_RUN;
            ST_RUN:  state_n = ST_RUN;
            default: state_n = ST_INIT;
        endcase
        if (flush)
            state_n = ST_INIT;
    end

    // Shifting through a GHR_BITS+1 vector keeps GHR_BITS=1 legal without special cases.
    assign pred_shift = {ghr, pred_dir};
    assign rep_shift  = {update_ghr, update_taken};

    always_comb begin
        ghr_n = ghr;
        if (flush)
            ghr_n = '0;
        else if (repair)
            ghr_n = rep_shift[GHR_BITS-1:0];
        else if (pred_go)
            ghr_n = pred_shift[GHR_BITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            ptr   <= '0;
            ghr   <= '0;
        end else begin
            state <= state_n;
            ghr   <= ghr_n;
            if (flush || state != ST_INIT)
                ptr <= '0;
            else
                ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_ghr   <= '0;
        end else begin
            pred_valid <= pred_go;
            if (pred_go)
                pred_ghr <= ghr;
        end
    end

    assign pred_taken = rd_ctr[CTR_BITS-1];

    // Stats survive flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_predictions <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (pred_go && stat_predictions != STAT_MAX)
                stat_predictions <= stat_predictions + 1'b1;
            if (repair && stat_mispredicts != STAT_MAX)
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

    assign unused_bits = ^{predict_pc, update_pc, pidx32, uidx32, pred_shift, rep_shift, rd_ctr};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench for gshare_branch_predictor at INDEX_BITS=GHR_BITS=4, CTR_BITS=2.
module tb_gshare_branch_predictor;

    localparam int PW = 32;
    localparam int IB = 4;
    localparam int GB = 4;
    localparam int CB = 2;
    localparam int SW = 16;

    logic          clk, rst, flush, ready;
    logic          predict_req, pred_valid, pred_taken;
    logic [PW-1:0] predict_pc, update_pc;
    logic [GB-1:0] pred_ghr, update_ghr;
    logic          update_valid, update_taken, update_mispredict;
    logic [SW-1:0] stat_predictions, stat_mispredicts;

    gshare_branch_predictor #(
        .PC_WIDTH(PW), .INDEX_BITS(IB), .GHR_BITS(GB), .CTR_BITS(CB), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .ready(ready),
        .predict_req(predict_req), .predict_pc(predict_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
        .update_valid(update_valid), .update_pc(update_pc), .update_ghr(update_ghr),
        .update_taken(update_taken), .update_mispredict(update_mispredict),
        .stat_predictions(stat_predictions), .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [1:0] m_pht [16];
    logic [3:0] m_ghr;
    int         m_preds, m_mis;
    logic [4:0] sb [$];
    logic [4:0] mon_e;
    int         n_checks, n_pass;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_pht[i] = 2'b01;
        m_ghr = 4'd0;
    endtask

    // One RUN-state cycle: drive inputs, advance the model, then clock.
    task automatic cyc(input bit pr, input logic [31:0] ppc, input bit uv, input logic [31:0] upc,
                       input logic [3:0] ug, input bit ut, input bit um);
        logic [3:0] pi, ui;
        bit rep;
        predict_req = pr; predict_pc = ppc;
        update_valid = uv; update_pc = upc; update_ghr = ug;
        update_taken = ut; update_mispredict = um;
        rep = uv && um;
        if (pr && !rep) begin
            pi = ppc[5:2] ^ m_ghr;
            sb.push_back({m_pht[pi][1], m_ghr});
            m_ghr = {m_ghr[2:0], m_pht[pi][1]};
            m_preds++;
        end
        if (uv) begin
            ui = upc[5:2] ^ ug;
            if (ut) begin
                if (m_pht[ui] != 2'd3) m_pht[ui] = m_pht[ui] + 2'd1;
            end else begin
                if (m_pht[ui] != 2'd0) m_pht[ui] = m_pht[ui] - 2'd1;
            end
            if (um) begin
                m_ghr = {ug[2:0], ut};
                m_mis++;
            end
        end
        @(posedge clk); #1;
        predict_req = 1'b0; update_valid = 1'b0; update_mispredict = 1'b0; update_taken = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic drain(input string name);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) $display("FAIL %s drain: %0d predictions outstanding, want 0", name, sb.size());
        else n_pass++;
    endtask

    // Scoreboard pop on every produced prediction.
    always @(negedge clk) begin
        if (!rst && pred_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL pred_unexpected: got taken=%b ghr=%h, none expected", pred_taken, pred_ghr);
            end else begin
                mon_e = sb.pop_front();
                if ({pred_taken, pred_ghr} !== mon_e)
                    $display("FAIL pred_out: got taken=%b ghr=%h, want taken=%b ghr=%h",
                             pred_taken, pred_ghr, mon_e[4], mon_e[3:0]);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        int n;
        rst = 1'b1; flush = 1'b0;
        predict_req = 1'b0; predict_pc = '0; update_valid = 1'b0; update_pc = '0;
        update_ghr = '0; update_taken = 1'b0; update_mispredict = 1'b0;
        m_preds = 0; m_mis = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ready, pred_valid, pred_taken, pred_ghr, stat_predictions, stat_mispredicts} !== '0)
            $display("FAIL reset_outputs: got ready=%b pv=%b pt=%b pg=%h sp=%0d sm=%0d, want all 0",
                     ready, pred_valid, pred_taken, pred_ghr, stat_predictions, stat_mispredicts);
        else n_pass++;
        rst = 1'b0;
        wait_ready(n);
        n_checks++;
        if (n !== 16) $display("FAIL reset_sweep_len: got %0d cycles, want 16", n);
        else n_pass++;
    endtask

    task automatic test_first_predict();
        cyc(1, 32'h1000, 0, 0, 0, 0, 0);
        n_checks++;
        if ({pred_valid, pred_taken, pred_ghr} !== 6'b10_0000)
            $display("FAIL first_predict: got pv=%b pt=%b ghr=%h, want pv=1 pt=0 ghr=0", pred_valid, pred_taken, pred_ghr);
        else n_pass++;
        drain("first_predict");
    endtask

    task automatic test_train();
        cyc(1, 32'h2000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h2000, 4'd0, 1, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 32'h2000, 4'd1, 1, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 32'h2000, 4'd3, 1, 0);
        drain("train");
    endtask

    task automatic test_taken_chain();
        logic [3:0] want [4];
        want[0] = 4'd0; want[1] = 4'd1; want[2] = 4'd3; want[3] = 4'd7;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h2000, 0, 0, 0, 0, 0);
            n_checks++;
            if (pred_ghr !== want[i] || pred_taken !== (i < 3))
                $display("FAIL taken_chain[%0d]: got pt=%b ghr=%h, want pt=%b ghr=%h",
                         i, pred_taken, pred_ghr, (i < 3), want[i]);
            else n_pass++;
        end
        drain("taken_chain");
    endtask

    task automatic test_mispredict();
        cyc(0, 0, 1, 32'h3000, 4'b0101, 0, 1);
        n_checks++;
        if (stat_mispredicts !== 16'd1) $display("FAIL mispredict_stat: got %0d, want 1", stat_mispredicts);
        else n_pass++;
        cyc(1, 32'h3000, 0, 0, 0, 0, 0);
        n_checks++;
        if (pred_ghr !== 4'b1010) $display("FAIL mispredict_repair: got ghr=%b, want 1010", pred_ghr);
        else n_pass++;
        drain("mispredict");
    endtask

    task automatic test_drop();
        cyc(1, 32'h1000, 1, 32'h1000, 4'b0011, 1, 1);
        n_checks++;
        if (pred_valid !== 1'b0 || stat_predictions !== 16'(m_preds) || stat_mispredicts !== 16'd2)
            $display("FAIL drop: got pv=%b sp=%0d sm=%0d, want pv=0 sp=%0d sm=2",
                     pred_valid, stat_predictions, stat_mispredicts, m_preds);
        else n_pass++;
        cyc(1, 32'h1000, 0, 0, 0, 0, 0);
        n_checks++;
        if (pred_ghr !== 4'b0111) $display("FAIL drop_repair: got ghr=%b, want 0111", pred_ghr);
        else n_pass++;
        drain("drop");
    endtask

    task automatic test_back_to_back();
        // Same index predicted and updated taken: read returns the old weak-NT value.
        cyc(1, 32'h1000, 1, 32'h1000, 4'b1110, 1, 0);
        n_checks++;
        if (pred_taken !== 1'b0 || pred_ghr !== 4'b1110)
            $display("FAIL rbw: got pt=%b ghr=%b, want pt=0 ghr=1110", pred_taken, pred_ghr);
        else n_pass++;
        for (int i = 0; i < 150; i++)
            cyc($urandom_range(0, 1), $urandom & 32'h3c, $urandom_range(0, 1), $urandom & 32'h3c,
                4'($urandom_range(0, 15)), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
        drain("random");
        n_checks++;
        if (stat_predictions !== 16'(m_preds) || stat_mispredicts !== 16'(m_mis))
            $display("FAIL stats: got sp=%0d sm=%0d, want sp=%0d sm=%0d",
                     stat_predictions, stat_mispredicts, m_preds, m_mis);
        else n_pass++;
    endtask

    task automatic test_flush();
        int n;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
        wait_ready(n);
        n_checks++;
        if (n !== 16) $display("FAIL flush_sweep_len: got %0d cycles, want 16", n);
        else n_pass++;
        n_checks++;
        if (stat_predictions !== 16'(m_preds) || stat_mispredicts !== 16'(m_mis))
            $display("FAIL flush_stats: got sp=%0d sm=%0d, want sp=%0d sm=%0d",
                     stat_predictions, stat_mispredicts, m_preds, m_mis);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 32'(i) << 2, 0, 0, 0, 0, 0);
            n_checks++;
            if (pred_taken !== 1'b0 || pred_ghr !== 4'd0)
                $display("FAIL flush_clear[%0d]: got pt=%b ghr=%h, want pt=0 ghr=0", i, pred_taken, pred_ghr);
            else n_pass++;
        end
        drain("flush");
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        test_reset();
        test_first_predict();
        test_train();
        test_taken_chain();
        test_mispredict();
        test_drop();
        test_back_to_back();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
